// File: rtl/fifo2axis.sv
// ----------------------------------------------------------------------------
// fifo2axis : drains wide FIFO words into a narrow AXI-Stream, MSB slice first,
//             with USER on the first beat and TLAST on the last beat of a frame.
// Revision  : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module fifo2axis #(
  parameter int FAW             = 8,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH = 128,
  parameter int FRAME_WORDS     = 16
) (
  input  logic                         S_AXIS_ACLK,
  input  logic                         S_AXIS_ARESETN,
  input  logic                         en,
  output logic                         frd_rdy,
  input  logic                         frd_vld,
  input  logic [AXI4_DATA_WIDTH-1:0]   frd_dat,
  input  logic                         frd_empty,
  input  logic [FAW:0]                 frd_cnt,
  output logic                         M_AXIS_TVALID,
  input  logic                         M_AXIS_TREADY,
  output logic [AXIS_DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [AXIS_DATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                         M_AXIS_TLAST,
  output logic                         M_AXIS_USER,
  output logic                         err_ovf
);

  localparam int RATIO = AXI4_DATA_WIDTH / AXIS_DATA_WIDTH;
  localparam int BW    = $clog2(RATIO);
  localparam int WW    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [BW-1:0] c_B_LAST = BW'(RATIO - 1);
  localparam logic [WW-1:0] c_W_LAST = WW'(FRAME_WORDS - 1);

  logic [AXI4_DATA_WIDTH-1:0] r_head;
  logic [AXI4_DATA_WIDTH-1:0] r_next;
  logic [1:0]                 r_occ;
  logic                       r_pend;
  logic                       r_run;
  logic                       r_err;
  logic [BW-1:0]              r_b;
  logic [WW-1:0]              r_w;

  logic                       w_vld_out;
  logic [1:0]                 w_cmt;
  logic                       w_rdy;
  logic                       w_xfer;
  logic                       w_blast;
  logic                       w_pop;
  logic                       w_wr;
  logic [AXIS_DATA_WIDTH-1:0] w_slice [RATIO];
  logic                       w_unused;

  // Occupancy is informational only; folded here so it is visibly consumed.
  assign w_unused  = ^frd_cnt;

  assign w_vld_out = (r_occ != 2'd0);
  // Slots already committed: buffered words plus the one still in flight.
  assign w_cmt     = r_occ + {1'b0, r_pend};
  assign w_rdy     = r_run & en & ~frd_empty & (w_cmt < 2'd2);
  assign w_xfer    = w_vld_out & M_AXIS_TREADY;
  assign w_blast   = (r_b == c_B_LAST);
  assign w_pop     = w_xfer & w_blast;
  assign w_wr      = frd_vld & r_pend;

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
    assign w_slice[gi] = r_head[AXI4_DATA_WIDTH-1-gi*AXIS_DATA_WIDTH -: AXIS_DATA_WIDTH];
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      r_head <= '0;
      r_next <= '0;
      r_occ  <= 2'd0;
      r_pend <= 1'b0;
      r_run  <= 1'b0;
      r_err  <= 1'b0;
      r_b    <= '0;
      r_w    <= '0;
    end else begin
      r_run  <= 1'b1;
      r_pend <= w_rdy;
      if (frd_vld && !r_pend) begin
        r_err <= 1'b1;
      end
      if (w_xfer) begin
        r_b <= w_blast ? '0 : r_b + 1'b1;
      end
      if (w_pop) begin
        r_w <= (r_w == c_W_LAST) ? '0 : r_w + 1'b1;
      end
      case ({w_pop, w_wr})
        2'b10: begin
          r_head <= r_next;
          r_occ  <= r_occ - 2'd1;
        end
        2'b01: begin
          if (r_occ == 2'd0) begin
            r_head <= frd_dat;
          end else begin
            r_next <= frd_dat;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b11: begin
          // Pop and refill together: the new word lands behind whatever remains.
          if (r_occ == 2'd1) begin
            r_head <= frd_dat;
          end else begin
            r_head <= r_next;
            r_next <= frd_dat;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign frd_rdy       = w_rdy;
  assign M_AXIS_TVALID = w_vld_out;
  assign M_AXIS_TDATA  = w_vld_out ? w_slice[r_b] : '0;
  assign M_AXIS_TSTRB  = {(AXIS_DATA_WIDTH/8){w_vld_out}};
  assign M_AXIS_TLAST  = w_vld_out & w_blast & (r_w == c_W_LAST);
  assign M_AXIS_USER   = w_vld_out & (r_b == '0) & (r_w == '0);
  assign err_ovf       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fifo2axis.sv
// ----------------------------------------------------------------------------
// tb_fifo2axis : scoreboard bench for fifo2axis with a fixed-latency FIFO model.
// Revision     : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fifo2axis;

  localparam int FAW = 8;
  localparam int AW  = 32;
  localparam int DW  = 128;
  localparam int FW  = 16;
  localparam int R   = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           frd_vld = 1'b0;
  logic [DW-1:0]  frd_dat = '0;
  logic           frd_empty = 1'b1;
  logic [FAW:0]   frd_cnt = '0;
  logic           tready = 1'b0;
  logic           frd_rdy;
  logic           tvalid;
  logic [AW-1:0]  tdata;
  logic [AW/8-1:0] tstrb;
  logic           tlast;
  logic           tuser;
  logic           err_ovf;

  fifo2axis #(
    .FAW(FAW), .AXIS_DATA_WIDTH(AW), .AXI4_DATA_WIDTH(DW), .FRAME_WORDS(FW)
  ) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .en(en),
    .frd_rdy(frd_rdy), .frd_vld(frd_vld), .frd_dat(frd_dat),
    .frd_empty(frd_empty), .frd_cnt(frd_cnt),
    .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready), .M_AXIS_TDATA(tdata),
    .M_AXIS_TSTRB(tstrb), .M_AXIS_TLAST(tlast), .M_AXIS_USER(tuser),
    .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] d;
    logic          u;
    logic          l;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] fq[$];
  logic [DW-1:0] words [32];
  int  checks = 0;
  int  errors = 0;
  int  tb_w = 0;
  int  issued = 0;
  int  popped = 0;
  int  beats = 0;
  int  bw_cnt = 0;
  int  inj_req = 0;
  int  inj_done = 0;
  bit  rand_ready = 1'b0;
  bit  have_prev = 1'b0;
  logic          pv_valid, pv_ready, pv_user, pv_last;
  logic [AW-1:0] pv_data;

  // FIFO model: one-cycle read latency, optional stray-valid injection.
  always @(posedge clk) begin
    frd_vld <= 1'b0;
    if (!rst_n) begin
      issued <= 0;
    end else if (frd_rdy && !frd_empty) begin
      frd_vld <= 1'b1;
      frd_dat <= fq.pop_front();
      issued  <= issued + 1;
    end else if (inj_req != inj_done) begin
      frd_vld  <= 1'b1;
      frd_dat  <= {4{32'hDEADBEEF}};
      inj_done <= inj_req;
    end
    frd_empty <= (fq.size() == 0);
    frd_cnt   <= (FAW+1)'(fq.size());
  end

  // Stream monitor and TREADY driver.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      popped    = 0;
      bw_cnt    = 0;
      have_prev = 1'b0;
    end else begin
      if (frd_rdy) begin
        checks++;
        if (issued - popped >= 2) begin
          errors++;
          $display("FAIL rdy_when_full: frd_rdy=1 with committed=%0d, required < 2", issued - popped);
        end
      end
      if (have_prev && pv_valid && !pv_ready) begin
        checks++;
        if ({tvalid, tdata, tuser, tlast} !== {1'b1, pv_data, pv_user, pv_last}) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h u=%b l=%b, required v=1 d=%h u=%b l=%b",
                   tvalid, tdata, tuser, tlast, pv_data, pv_user, pv_last);
        end
      end
      tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tvalid && tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got d=%h with nothing expected", tdata);
        end else begin
          e = exp_q.pop_front();
          if ({tdata, tuser, tlast, tstrb} !== {e.d, e.u, e.l, 4'hF}) begin
            errors++;
            $display("FAIL beat%0d: got d=%h u=%b l=%b s=%h, required d=%h u=%b l=%b s=f",
                     beats, tdata, tuser, tlast, tstrb, e.d, e.u, e.l);
          end
        end
        beats++;
        bw_cnt++;
        if (bw_cnt == R) begin
          bw_cnt = 0;
          popped++;
        end
      end
      have_prev = 1'b1;
      pv_valid  = tvalid;
      pv_ready  = tready;
      pv_data   = tdata;
      pv_user   = tuser;
      pv_last   = tlast;
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    beat_t b;
    fq.push_back(w);
    for (int k = 0; k < R; k++) begin
      b.d = w[DW-1-k*AW -: AW];
      b.u = (tb_w == 0) && (k == 0);
      b.l = (tb_w == FW-1) && (k == R-1);
      exp_q.push_back(b);
    end
    tb_w = (tb_w + 1) % FW;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    fq.delete();
    exp_q.delete();
    tb_w  = 0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && fq.size() == 0 && !tvalid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    beat_t b;
    en = 1'b1;
    fq.push_back(128'h00112233_44556677_8899AABB_CCDDEEFF);
    b = '{d: 32'h00112233, u: 1'b1, l: 1'b0}; exp_q.push_back(b);
    b = '{d: 32'h44556677, u: 1'b0, l: 1'b0}; exp_q.push_back(b);
    b = '{d: 32'h8899AABB, u: 1'b0, l: 1'b0}; exp_q.push_back(b);
    b = '{d: 32'hCCDDEEFF, u: 1'b0, l: 1'b0}; exp_q.push_back(b);
    tb_w = 1;
    repeat (3) tick();
    checks++;
    if ({frd_rdy, tvalid, tdata, tstrb, tlast, tuser, err_ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b v=%b d=%h s=%h l=%b u=%b e=%b, required all 0",
               frd_rdy, tvalid, tdata, tstrb, tlast, tuser, err_ovf);
    end
  endtask

  task automatic test_basic;
    bit ok;
    bit seen = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (frd_rdy) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL first_read: got frd_rdy=0 for 10 cycles, required 1");
    end
    tick();
    checks++;
    if (tvalid !== 1'b0) begin
      errors++;
      $display("FAIL latency_t1: got tvalid=%b, required 0", tvalid);
    end
    tick();
    checks++;
    if (tvalid !== 1'b1) begin
      errors++;
      $display("FAIL latency_t2: got tvalid=%b, required 1", tvalid);
    end
    wait_drain(50, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_drain: got %0d beats left, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int bubbles = 0;
    int b0;
    do_reset();
    rand_ready = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      words[i] = {$urandom, $urandom, $urandom, $urandom};
      push_word(words[i]);
    end
    b0 = beats;
    for (int i = 0; i < 20 && !tvalid; i++) tick();
    for (int i = 0; i < 32*R; i++) begin
      if (!tvalid) bubbles++;
      tick();
    end
    checks++;
    if (bubbles != 0) begin
      errors++;
      $display("FAIL b2b_bubbles: got %0d idle cycles, required 0", bubbles);
    end
    wait_drain(50, ok);
    checks++;
    if (!ok || beats - b0 != 32*R) begin
      errors++;
      $display("FAIL b2b_count: got %0d beats, required %0d", beats - b0, 32*R);
    end
  endtask

  task automatic test_random_ready;
    bit ok;
    do_reset();
    rand_ready = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 32; i++) push_word(words[i]);
    wait_drain(2000, ok);
    rand_ready = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL random_drain: got %0d beats left, required 0", exp_q.size());
    end
  endtask

  task automatic test_en;
    bit ok;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 6; i++) push_word({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 40 && issued < 3; i++) tick();
    en = 1'b0;
    repeat (30) tick();
    checks++;
    if ({tvalid, 32'(exp_q.size()), 32'(fq.size())} !== {1'b0, 32'd12, 32'd3}) begin
      errors++;
      $display("FAIL en_stop: got tvalid=%b beats_left=%0d fifo=%0d, required 0/12/3",
               tvalid, exp_q.size(), fq.size());
    end
    en = 1'b1;
    wait_drain(100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL en_resume: got %0d beats left, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int b0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 8; i++) push_word({$urandom, $urandom, $urandom, $urandom});
    b0 = beats;
    for (int i = 0; i < 40 && beats - b0 < 6; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({frd_rdy, tvalid, tdata, tstrb, tlast, tuser} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got rdy=%b v=%b d=%h s=%h l=%b u=%b, required all 0",
               frd_rdy, tvalid, tdata, tstrb, tlast, tuser);
    end
    repeat (2) tick();
    fq.delete();
    exp_q.delete();
    tb_w  = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push_word({$urandom, $urandom, $urandom, $urandom});
    wait_drain(100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midreset_restart: got %0d beats left, required 0", exp_q.size());
    end
  endtask

  task automatic test_ovf;
    bit ok;
    do_reset();
    en = 1'b0;
    repeat (3) tick();
    checks++;
    if (err_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got err_ovf=%b, required 0", err_ovf);
    end
    inj_req++;
    repeat (3) tick();
    checks++;
    if ({err_ovf, tvalid} !== 2'b10) begin
      errors++;
      $display("FAIL ovf_set: got err_ovf=%b tvalid=%b, required 1/0", err_ovf, tvalid);
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) push_word({$urandom, $urandom, $urandom, $urandom});
    wait_drain(100, ok);
    checks++;
    if (!ok || err_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got drained=%b err_ovf=%b, required 1/1", ok, err_ovf);
    end
    do_reset();
    checks++;
    if (err_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_reset: got err_ovf=%b, required 0", err_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_random_ready();
    test_en();
    test_reset_mid();
    test_ovf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
